div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have port: clk  input  1  core clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  request a divide; sampled only in IDLE.
REQ-004 SHALL have port: funct3  input  3  op select: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port: a  input  32  dividend.
REQ-006 SHALL have port: b  input  32  divisor.
REQ-007 SHALL have port: flush  input  1  abort the operation in flight.
REQ-008 SHALL have port: busy  output  1  operation in progress; pipeline stalls EX while high.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port: result  output  32  quotient or remainder per latched funct3.

Function
REQ-011 SHALL implement states IDLE, CALC, FIX, DONE.
REQ-012 IDLE, start=1, flush=0: latch funct3, |a|, |b|, sign flags; clear 6-bit counter; go to CALC.
REQ-013 CALC: one restoring shift-subtract step per cycle; 32 steps, then go to FIX.
REQ-014 FIX: apply signs (quotient negative iff signs differ and op signed; remainder takes dividend sign); select quotient/remainder; register result; go to DONE.
REQ-015 DONE: done=1 for exactly one cycle; then IDLE.
REQ-016 With start in cycle 0, busy SHALL be 1 in cycles 1-33, done=1 in cycle 34, busy=0 in cycle 34.
REQ-017 start outside IDLE SHALL be ignored; operands SHALL NOT be re-latched.
REQ-018 Divisor zero: quotient 0xFFFFFFFF (all ops), remainder = a.
REQ-019 Signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0.
REQ-020 Absolute values SHALL use 33-bit arithmetic so 0x80000000 does not wrap.
REQ-021 flush in CALC/FIX/DONE: return to IDLE next cycle, done stays 0, result unchanged.
REQ-022 flush and start both high in IDLE: flush wins, no operation accepted.
REQ-023 result SHALL hold its value until the next FIX/early-out write.

Reset
REQ-024 reset asserted: state IDLE, busy 0, done 0, result 0x00000000, counter 0, immediately and independent of clk.
REQ-025 reset mid-operation SHALL discard the operation; no done after release.
REQ-026 First start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-027 Macro DIV_EARLY_OUT_EN, when defined: divisor zero, overflow, or |a|<|b| SHALL skip CALC/FIX, write result from IDLE and reach DONE, with done=1 in cycle 1 and busy never 1.
REQ-028 Without DIV_EARLY_OUT_EN: every op SHALL take fixed 34-cycle latency per REQ-016.
REQ-029 result values SHALL be identical with and without the macro.

Verification
REQ-030 DIVU a=100 b=7, start cycle 0 -> done cycle 34, result 14; REMU same -> 2.
REQ-031 REM a=0xFFFFFFF9 (-7) b=2 -> result 0xFFFFFFFF (-1); DIV same -> 0xFFFFFFFD (-3).
REQ-032 DIV a=5 b=0 -> result 0xFFFFFFFF; REM -> 5; with DIV_EARLY_OUT_EN done in cycle 1.
REQ-033 DIV a=0x80000000 b=0xFFFFFFFF -> result 0x80000000; REM -> 0.
REQ-034 DIVU 1000/3, flush in cycle 10 -> IDLE cycle 11, no done, result unchanged; new start cycle 11 -> done cycle 45.
REQ-035 reset asserted in cycle 20 of an operation -> busy, done, result 0 immediately; no done after release.

Source files
------------

// File: rtl/div_seq.sv
// Multi-cycle 32-bit divider (DIV/DIVU/REM/REMU) using a restoring shift-subtract loop.
// Define DIV_EARLY_OUT_EN to finish zero-divisor, overflow and |a|<|b| cases straight from IDLE.
module div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [32:0] dvs;
    logic        neg_q, neg_r, is_rem, b_zero;

    logic        sgn_op;
    logic [32:0] a_ext, b_ext, abs_a, abs_b;
    logic [32:0] rem_sh, diff;
    logic [31:0] q_fix, r_fix;
    logic        early;
    logic [31:0] early_res;
    logic        unused_bits;

    // Magnitudes are 33 bits wide so that -2^31 becomes +2^31 instead of wrapping.
    assign sgn_op = ~funct3[0];
    assign a_ext  = {sgn_op & a[31], a};
    assign b_ext  = {sgn_op & b[31], b};
    assign abs_a  = (sgn_op & a[31]) ? 33'd0 - a_ext : a_ext;
    assign abs_b  = (sgn_op & b[31]) ? 33'd0 - b_ext : b_ext;

    assign rem_sh = {rem, quo[31]};
    assign diff   = rem_sh - dvs;

    assign q_fix  = neg_q ? 32'd0 - quo : quo;
    assign r_fix  = neg_r ? 32'd0 - rem : rem;

`ifdef DIV_EARLY_OUT_EN
    logic ovf;
    assign ovf       = sgn_op && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign early     = (b == 32'd0) || ovf || (abs_a < abs_b);
    assign early_res = funct3[1] ? ((b == 32'd0) ? a : (ovf ? 32'd0 : a))
                                 : ((b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'd0));
`else
    assign early     = 1'b0;
    assign early_res = 32'd0;
`endif

    assign unused_bits = abs_a[32] ^ funct3[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 32'd0;
            cnt    <= 6'd0;
            rem    <= 32'd0;
            quo    <= 32'd0;
            dvs    <= 33'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_rem <= 1'b0;
            b_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start && !flush) begin
                        cnt    <= 6'd0;
                        rem    <= 32'd0;
                        quo    <= abs_a[31:0];
                        dvs    <= abs_b;
                        neg_q  <= sgn_op & (a[31] ^ b[31]);
                        neg_r  <= sgn_op & a[31];
                        is_rem <= funct3[1];
                        b_zero <= (b == 32'd0);
                        if (early) begin
                            result <= early_res;
                            state  <= DONE;
                            done   <= 1'b1;
                        end else begin
                            state  <= CALC;
                            busy   <= 1'b1;
                        end
                    end
                    CALC: begin
                        if (diff[32]) begin
                            rem <= rem_sh[31:0];
                            quo <= {quo[30:0], 1'b0};
                        end else begin
                            rem <= diff[31:0];
                            quo <= {quo[30:0], 1'b1};
                        end
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd31) state <= FIX;
                    end
                    FIX: begin
                        // A zero divisor leaves quo all-ones; it must not be sign-flipped.
                        result <= is_rem ? r_fix : (b_zero ? 32'hFFFF_FFFF : q_fix);
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: stimulus queues expected result/cycle, a negedge monitor checks on done.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b100;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] result;

    div_seq dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    typedef struct { logic [31:0] res; int at; } exp_t;
    exp_t sb[$];

    typedef struct { logic [2:0] f; logic [31:0] a; logic [31:0] b; logic [31:0] r; bit eo; } vec_t;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    vec_t vecs [18] = '{
        '{DIVU, 32'd100,        32'd7,          32'd14,         1'b0},
        '{REMU, 32'd100,        32'd7,          32'd2,          1'b0},
        '{REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0},
        '{DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0},
        '{DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1},
        '{REM,  32'd5,          32'd0,          32'd5,          1'b1},
        '{DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1},
        '{REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1},
        '{DIVU, 32'd3,          32'd1000,       32'd0,          1'b1},
        '{REMU, 32'd3,          32'd1000,       32'd3,          1'b1},
        '{DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0},
        '{DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  1'b0},
        '{REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  1'b0},
        '{DIV,  32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  1'b0},
        '{REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          1'b0},
        '{DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1},
        '{REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1},
        '{REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1'b1}
    };

    int passed = 0;
    int total  = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got done=1 want no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("done_cycle", cyc, e.at);
            end
        end
    end

    // Caller is positioned at a negedge; start is sampled by the next posedge.
    task automatic issue(input logic [2:0] f, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] r, input int lat, input bit push);
        exp_t e;
        start = 1'b1; funct3 = f; a = aa; b = bb;
        e.res = r; e.at = cyc + lat;
        if (push) sb.push_back(e);
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic watch(input int lat, input string nm);
        bit got = 0, bad = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1;
                if (busy !== 1'b0) bad = 1;
            end else if (busy !== (lat > 1)) bad = 1;
        end
        total++;
        if (got && !bad) passed++;
        else $display("FAIL %s busy/done profile: got done_seen=%0d busy_err=%0d want 1/0", nm, got, bad);
    endtask

    task automatic run_vec(input int i);
        int lat;
        lat = (EO && vecs[i].eo) ? 1 : 34;
        @(negedge clk);
        issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r, lat, 1'b1);
        watch(lat, $sformatf("vec%0d", i));
    endtask

    initial begin
        int c0;
        logic [31:0] last;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        // First start on the very first edge after release.
        issue(DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b1);
        watch(34, "first_after_reset");

        for (int i = 0; i < 18; i++) run_vec(i);

        // A start while busy must not re-latch operands.
        @(negedge clk);
        c0 = cyc;
        issue(DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b1);
        while (cyc < c0 + 5) @(negedge clk);
        start = 1'b1; funct3 = REMU; a = 32'd1; b = 32'd1;
        @(negedge clk); start = 1'b0;
        watch(34, "start_while_busy");
        last = 32'd14;

        // Flush in cycle 10, restart in cycle 11.
        @(negedge clk);
        c0 = cyc;
        issue(DIVU, 32'd1000, 32'd3, 32'd333, 34, 1'b0);
        while (cyc < c0 + 10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle_busy", {31'd0, busy}, 32'd0);
        chk("flush_result_held", result, last);
        chk("flush_cycle", cyc, c0 + 11);
        issue(DIVU, 32'd1000, 32'd3, 32'd333, 34, 1'b1);
        watch(34, "after_flush");
        last = 32'd333;

        // flush beats start in IDLE.
        @(negedge clk);
        flush = 1'b1; start = 1'b1; funct3 = DIVU; a = 32'd9; b = 32'd3;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        chk("flush_start_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        chk("flush_start_result", result, last);

        // Asynchronous reset mid-operation.
        c0 = cyc;
        issue(DIVU, 32'd1000, 32'd3, 32'd333, 34, 1'b1);
        while (cyc < c0 + 20) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        #1;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        chk("midreset_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_reset_result", result, 32'd0);

        // Early-out capable op right after a fresh release.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        issue(DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, EO ? 1 : 34, 1'b1);
        watch(EO ? 1 : 34, "zero_after_reset");

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
